mat_mem_arbiter: RTL and testbench

- Shares the single row-wide matrix memory port (2*M rows of DATA_LEN*N bits) between two requesters.
  - Requester 0: host loader, which fills and drains matrices A and B.
  - Requester 1: mat_ops_controller, which runs the read / multiply / write sequence.
- Registered grant FSM with round-robin on contention, a burst cap and a lock override.
- Per-requester read-valid routing matched to the memory's 1-cycle registered read latency.

---
 rtl/mat_mem_arbiter.sv | 121 ++++++++++++
 tb/tb_mat_mem_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mat_mem_arbiter.sv
// Two-requester arbiter for the single row-wide matrix memory port: registered
// round-robin grant with a burst cap, lock override and per-requester read-valid routing.
module mat_mem_arbiter #(
  parameter int DATA_LEN     = 32,
  parameter int N            = 8,
  parameter int ADDRESS_SIZE = 4,
  parameter int MAX_BURST    = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_req0,
  input  logic                      i_req1,
  input  logic                      i_lock0,
  input  logic                      i_lock1,
  input  logic [ADDRESS_SIZE-1:0]   i_addr0,
  input  logic [ADDRESS_SIZE-1:0]   i_addr1,
  input  logic                      i_wr_en0,
  input  logic                      i_wr_en1,
  input  logic [DATA_LEN*N-1:0]     i_wdata0,
  input  logic [DATA_LEN*N-1:0]     i_wdata1,
  output logic                      o_gnt0,
  output logic                      o_gnt1,
  output logic                      o_rvalid0,
  output logic                      o_rvalid1,
  output logic [DATA_LEN*N-1:0]     o_rdata,
  output logic [ADDRESS_SIZE-1:0]   o_mem_addr,
  output logic                      o_mem_wr_en,
  output logic [DATA_LEN*N-1:0]     o_mem_wdata,
  input  logic [DATA_LEN*N-1:0]     i_mem_rdata,
  output logic [1:0]                o_state
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] burst_cnt, burst_cnt_nxt;
  logic             last_owner, last_owner_nxt;
  logic             acc0_p0, acc1_p0;
  logic             rd_vld0_p1, rd_vld1_p1;

  // Stage p0: grant decode and combinational port mux
  assign o_gnt0  = (state == OWN0);
  assign o_gnt1  = (state == OWN1);
  assign o_state = state;
  assign acc0_p0 = o_gnt0 & i_req0;
  assign acc1_p0 = o_gnt1 & i_req1;

  assign o_mem_addr  = acc1_p0 ? i_addr1  : i_addr0;
  assign o_mem_wdata = acc1_p0 ? i_wdata1 : i_wdata0;
  assign o_mem_wr_en = (acc0_p0 & i_wr_en0) | (acc1_p0 & i_wr_en1);

  always_comb begin
    state_nxt      = state;
    burst_cnt_nxt  = burst_cnt;
    last_owner_nxt = last_owner;
    case (state)
      IDLE: begin
        if (i_req0 && i_req1) state_nxt = last_owner ? OWN0 : OWN1;
        else if (i_req0)      state_nxt = OWN0;
        else if (i_req1)      state_nxt = OWN1;
      end
      OWN0: begin
        if (!i_req0)
          state_nxt = i_req1 ? OWN1 : IDLE;
        else if (burst_cnt == BURST_LAST && i_req1 && !i_lock0)
          state_nxt = OWN1;
      end
      OWN1: begin
        if (!i_req1)
          state_nxt = i_req0 ? OWN0 : IDLE;
        else if (burst_cnt == BURST_LAST && i_req0 && !i_lock1)
          state_nxt = OWN0;
      end
      default: state_nxt = IDLE;
    endcase

    // Count saturates at the cap so a locked owner keeps the grant indefinitely
    if (state_nxt != state)
      burst_cnt_nxt = '0;
    else if ((acc0_p0 || acc1_p0) && burst_cnt != BURST_LAST)
      burst_cnt_nxt = burst_cnt + 1'b1;

    if (state_nxt == OWN0)      last_owner_nxt = 1'b0;
    else if (state_nxt == OWN1) last_owner_nxt = 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      burst_cnt  <= '0;
      last_owner <= 1'b1;
    end else begin
      state      <= state_nxt;
      burst_cnt  <= burst_cnt_nxt;
      last_owner <= last_owner_nxt;
    end
  end

  // Stage p1: issuer tag travels with the read so the valid follows the issuer
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_vld0_p1 <= 1'b0;
      rd_vld1_p1 <= 1'b0;
    end else begin
      rd_vld0_p1 <= acc0_p0 & ~i_wr_en0;
      rd_vld1_p1 <= acc1_p0 & ~i_wr_en1;
    end
  end

  assign o_rvalid0 = rd_vld0_p1;
  assign o_rvalid1 = rd_vld1_p1;
  assign o_rdata   = i_mem_rdata;

endmodule

// File: tb/tb_mat_mem_arbiter.sv
// Directed bench for mat_mem_arbiter with a per-cycle behavioural ownership model.
module tb_mat_mem_arbiter;
  localparam int DATA_LEN  = 32;
  localparam int N         = 8;
  localparam int AS        = 4;
  localparam int MAX_BURST = 8;
  localparam int ROW_W     = DATA_LEN * N;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0 = 0, req1 = 0, lock0 = 0, lock1 = 0, wr0 = 0, wr1 = 0;
  logic [AS-1:0]    addr0 = '0, addr1 = '0;
  logic [ROW_W-1:0] wdata0 = '0, wdata1 = '0;
  logic gnt0, gnt1, rv0, rv1, mem_wr_en;
  logic [ROW_W-1:0] rdata, mem_wdata, mem_rdata;
  logic [AS-1:0]    mem_addr;
  logic [1:0]       state;

  int vectors = 0;
  int errors  = 0;

  mat_mem_arbiter #(.DATA_LEN(DATA_LEN), .N(N), .ADDRESS_SIZE(AS), .MAX_BURST(MAX_BURST)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req0(req0), .i_req1(req1), .i_lock0(lock0), .i_lock1(lock1),
    .i_addr0(addr0), .i_addr1(addr1), .i_wr_en0(wr0), .i_wr_en1(wr1),
    .i_wdata0(wdata0), .i_wdata1(wdata1),
    .o_gnt0(gnt0), .o_gnt1(gnt1), .o_rvalid0(rv0), .o_rvalid1(rv1),
    .o_rdata(rdata), .o_mem_addr(mem_addr), .o_mem_wr_en(mem_wr_en),
    .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata), .o_state(state)
  );

  always #5 clk = ~clk;

  function automatic logic [ROW_W-1:0] init_row(input int r);
    logic [ROW_W-1:0] v;
    for (int e = 0; e < N; e++) v[e*DATA_LEN +: DATA_LEN] = DATA_LEN'(r + (e << 16));
    return v;
  endfunction

  function automatic logic [ROW_W-1:0] wrow(input int i);
    logic [ROW_W-1:0] v;
    for (int e = 0; e < N; e++) v[e*DATA_LEN +: DATA_LEN] = DATA_LEN'(32'hA000_0000 + i * 16 + e);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Memory with one-cycle registered read; port sampled mid-cycle
  logic [ROW_W-1:0] mem [16];
  initial begin
    logic [AS-1:0]    c_addr;
    logic             c_wr;
    logic [ROW_W-1:0] c_wdata;
    for (int r = 0; r < 16; r++) mem[r] = init_row(r);
    forever begin
      @(negedge clk);
      c_addr = mem_addr; c_wr = mem_wr_en; c_wdata = mem_wdata;
      @(posedge clk);
      mem_rdata = mem[c_addr];
      if (c_wr) mem[c_addr] = c_wdata;
    end
  end

  // Behavioural model: owner id (2 = nobody), accesses done in this grant, last winner
  int               m_owner = 2;
  int               m_done  = 0;
  int               m_last  = 1;
  bit               m_pv    = 0;
  int               m_pwho  = 0;
  logic [ROW_W-1:0] m_pdata;
  logic [ROW_W-1:0] m_mem [16];

  task automatic model_step();
    logic             rq [2];
    logic             wr [2];
    logic             lk [2];
    logic [AS-1:0]    ad [2];
    logic [ROW_W-1:0] wd [2];
    bit               acc;
    int               nxt, oth;
    logic [1:0]       exp_state;
    if (rst) begin
      m_owner = 2; m_done = 0; m_last = 1; m_pv = 0;
      chk("rst_gnt0", ROW_W'(gnt0), '0);
      chk("rst_gnt1", ROW_W'(gnt1), '0);
      chk("rst_rvalid0", ROW_W'(rv0), '0);
      chk("rst_rvalid1", ROW_W'(rv1), '0);
      chk("rst_wr_en", ROW_W'(mem_wr_en), '0);
      chk("rst_state", ROW_W'(state), '0);
      return;
    end
    rq[0] = req0; rq[1] = req1; wr[0] = wr0; wr[1] = wr1; lk[0] = lock0; lk[1] = lock1;
    ad[0] = addr0; ad[1] = addr1; wd[0] = wdata0; wd[1] = wdata1;
    acc = (m_owner != 2) && rq[m_owner];
    exp_state = (m_owner == 2) ? 2'd0 : 2'(m_owner + 1);
    chk("gnt0", ROW_W'(gnt0), ROW_W'(m_owner == 0));
    chk("gnt1", ROW_W'(gnt1), ROW_W'(m_owner == 1));
    chk("state", ROW_W'(state), ROW_W'(exp_state));
    chk("mem_addr", ROW_W'(mem_addr), ROW_W'(acc ? ad[m_owner] : ad[0]));
    chk("mem_wdata", mem_wdata, acc ? wd[m_owner] : wd[0]);
    chk("mem_wr_en", ROW_W'(mem_wr_en), ROW_W'(acc && wr[m_owner]));
    chk("rvalid0", ROW_W'(rv0), ROW_W'(m_pv && m_pwho == 0));
    chk("rvalid1", ROW_W'(rv1), ROW_W'(m_pv && m_pwho == 1));
    if (m_pv) chk("rdata", rdata, m_pdata);
    m_pv = 0;
    if (acc && !wr[m_owner]) begin
      m_pv = 1; m_pwho = m_owner; m_pdata = m_mem[ad[m_owner]];
    end
    if (acc && wr[m_owner]) m_mem[ad[m_owner]] = wd[m_owner];
    if (m_owner == 2) begin
      if (rq[0] && rq[1]) nxt = 1 - m_last;
      else if (rq[0])     nxt = 0;
      else if (rq[1])     nxt = 1;
      else                nxt = 2;
    end else begin
      oth = 1 - m_owner;
      nxt = m_owner;
      if (!rq[m_owner])                                         nxt = rq[oth] ? oth : 2;
      else if (m_done >= MAX_BURST - 1 && rq[oth] && !lk[m_owner]) nxt = oth;
    end
    if (nxt != m_owner) begin
      m_done = 0;
      if (nxt != 2) m_last = nxt;
    end else if (acc) begin
      m_done++;
    end
    m_owner = nxt;
  endtask

  initial begin
    for (int r = 0; r < 16; r++) m_mem[r] = init_row(r);
    forever begin
      @(negedge clk);
      model_step();
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, rv, held, leaked;
    bit sw;
    #2;
    chk("t0_state", ROW_W'(state), '0);
    chk("t0_gnt0", ROW_W'(gnt0), '0);
    chk("t0_rvalid1", ROW_W'(rv1), '0);
    do_reset();

    // Test 1: requester 0 alone writes rows 0..3
    req0 = 1; wr0 = 1; addr0 = 0; wdata0 = wrow(0);
    #1 chk("t1_gnt_before", ROW_W'(gnt0), '0);
    step();
    for (int i = 0; i < 4; i++) begin
      addr0 = AS'(i); wdata0 = wrow(i);
      #1;
      chk("t1_wr_en", ROW_W'(mem_wr_en), ROW_W'(1));
      chk("t1_addr", ROW_W'(mem_addr), ROW_W'(i));
      chk("t1_state", ROW_W'(state), ROW_W'(1));
      step();
    end
    req0 = 0; wr0 = 0;
    #1 chk("t1_wr_en_off", ROW_W'(mem_wr_en), '0);
    step();
    #1 chk("t1_idle", ROW_W'(state), '0);

    // Test 2: tie after reset, handover without dead cycle, round-robin
    do_reset();
    req0 = 1; req1 = 1; addr0 = 1; addr1 = 2;
    step();
    #1 chk("t2_first_gnt0", ROW_W'(gnt0), ROW_W'(1));
    chk("t2_first_gnt1", ROW_W'(gnt1), '0);
    step();
    req0 = 0;
    step();
    #1 chk("t2_handover_gnt1", ROW_W'(gnt1), ROW_W'(1));
    chk("t2_handover_state", ROW_W'(state), ROW_W'(2));
    req1 = 0;
    step();
    #1 chk("t2_idle", ROW_W'(state), '0);
    req0 = 1; req1 = 1;
    step();
    #1 chk("t2_rr_gnt0", ROW_W'(gnt0), ROW_W'(1));
    req0 = 0; req1 = 0;
    step();
    step();

    // Test 3: burst cap hands over after MAX_BURST reads
    req1 = 1; wr1 = 0; addr1 = 0;
    step();
    req0 = 1; addr0 = 3;
    acc = 0; rv = 0; sw = 0;
    for (int k = 0; k < 20; k++) begin
      addr1 = AS'(k);
      #1;
      if (rv1) rv++;
      if (gnt0) begin sw = 1; break; end
      if (gnt1) acc++;
      step();
    end
    chk("t3_switched", ROW_W'(sw), ROW_W'(1));
    chk("t3_accesses", ROW_W'(acc), ROW_W'(8));
    chk("t3_rvalid1_pulses", ROW_W'(rv), ROW_W'(8));
    req1 = 0;
    step();
    req0 = 0;
    step();
    step();

    // Test 4: lock keeps the grant past the cap
    req1 = 1; lock1 = 1; addr1 = 0;
    step();
    req0 = 1;
    held = 0; leaked = 0;
    for (int k = 0; k < 12; k++) begin
      addr1 = AS'(k);
      #1;
      if (gnt1) held++;
      if (gnt0) leaked++;
      step();
    end
    chk("t4_held", ROW_W'(held), ROW_W'(12));
    chk("t4_leaked", ROW_W'(leaked), '0);
    req1 = 0; lock1 = 0;
    #1 chk("t4_gnt1_release", ROW_W'(gnt1), ROW_W'(1));
    step();
    #1 chk("t4_gnt0_after", ROW_W'(gnt0), ROW_W'(1));
    req0 = 0;
    step();
    step();

    // Test 5: read of row 5 returns its element 0 to requester 1
    req1 = 1; wr1 = 0; addr1 = 5;
    step();
    step();
    req1 = 0;
    #1;
    chk("t5_rvalid1", ROW_W'(rv1), ROW_W'(1));
    chk("t5_rdata", ROW_W'(rdata[31:0]), ROW_W'(32'h0000_0005));
    chk("t5_rvalid0", ROW_W'(rv0), '0);
    step();
    step();

    // Test 6: async reset mid-burst with a read in flight
    req0 = 1; wr0 = 0; addr0 = 6;
    step();
    step();
    wr0 = 1; addr0 = 9; wdata0 = wrow(9);
    #1 chk("t6_rvalid0_pre", ROW_W'(rv0), ROW_W'(1));
    rst = 1;
    #1;
    chk("t6_gnt0", ROW_W'(gnt0), '0);
    chk("t6_rvalid0", ROW_W'(rv0), '0);
    chk("t6_wr_en", ROW_W'(mem_wr_en), '0);
    chk("t6_state", ROW_W'(state), '0);
    step();
    rst = 0; wr0 = 0;
    #1 chk("t6_gnt0_wait", ROW_W'(gnt0), '0);
    step();
    #1 chk("t6_gnt0_regrant", ROW_W'(gnt0), ROW_W'(1));
    req0 = 0;
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
